// File: rtl/mem_arbiter_if.sv
// Memory arbiter port bundle: I-cache and D-cache request channels, backing-memory command bus, wait counters.
// slave is the arbiter's view; master is the requester/memory view.
interface mem_arbiter_if #(
  parameter int WAIT_CNT_W = 16
);
  logic                  i_req;
  logic                  i_last;
  logic [31:0]           i_addr;
  logic                  i_gnt;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic                  d_last;
  logic [31:0]           d_addr;
  logic [31:0]           d_wdata;
  logic [3:0]            d_byte_en;
  logic                  d_gnt;
  logic [31:0]           d_rdata;

  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_byte_en;
  logic [31:0]           mem_rdata;

  logic [WAIT_CNT_W-1:0] i_wait_cnt;
  logic [WAIT_CNT_W-1:0] d_wait_cnt;

  modport slave (
    input  i_req, i_last, i_addr,
    input  d_req, d_we, d_last, d_addr, d_wdata, d_byte_en,
    input  mem_rdata,
    output i_gnt, i_rdata, d_gnt, d_rdata,
    output mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_byte_en,
    output i_wait_cnt, d_wait_cnt
  );

  modport master (
    output i_req, i_last, i_addr,
    output d_req, d_we, d_last, d_addr, d_wdata, d_byte_en,
    output mem_rdata,
    input  i_gnt, i_rdata, d_gnt, d_rdata,
    input  mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_byte_en,
    input  i_wait_cnt, d_wait_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (I-cache, D-cache) with locked multi-beat grants and round-robin tie-break.
// Grant one cycle after request; owner stalls by dropping req (strobes go low, grant held).
module mem_arbiter #(
  parameter int WAIT_CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  prio_i;
  logic                  i_gnt;
  logic                  d_gnt;
  logic                  grant_issued;
  logic                  rd_en;
  logic                  wr_en;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [3:0]            byte_en;
  logic [WAIT_CNT_W-1:0] i_wait_q;
  logic [WAIT_CNT_W-1:0] d_wait_q;

  assign i_gnt = (state == GNT_I);
  assign d_gnt = (state == GNT_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    byte_en   = 4'b0000;
    case (state)
      IDLE: begin
        if (bus.i_req && bus.d_req) begin
          state_nxt = prio_i ? GNT_I : GNT_D;
        end else if (bus.i_req) begin
          state_nxt = GNT_I;
        end else if (bus.d_req) begin
          state_nxt = GNT_D;
        end
      end
      GNT_I: begin
        if (bus.i_req) begin
          rd_en = 1'b1;
          addr  = bus.i_addr;
          // Handoff straight to the waiting side avoids an IDLE bubble.
          if (bus.i_last) begin
            state_nxt = bus.d_req ? GNT_D : IDLE;
          end
        end
      end
      GNT_D: begin
        if (bus.d_req) begin
          rd_en   = ~bus.d_we;
          wr_en   = bus.d_we;
          addr    = bus.d_addr;
          wdata   = bus.d_wdata;
          byte_en = bus.d_we ? bus.d_byte_en : 4'b0000;
          if (bus.d_last) begin
            state_nxt = bus.i_req ? GNT_I : IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // prio_i=1 means I wins the next tie; cleared on reset so D wins the first one.
  assign grant_issued = (state_nxt != state) && (state_nxt != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_i <= 1'b0;
    end else if (grant_issued) begin
      prio_i <= (state_nxt == GNT_D);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_wait_q <= '0;
      d_wait_q <= '0;
    end else begin
      if (bus.i_req && !i_gnt && (i_wait_q != '1)) begin
        i_wait_q <= i_wait_q + WAIT_CNT_W'(1);
      end
      if (bus.d_req && !d_gnt && (d_wait_q != '1)) begin
        d_wait_q <= d_wait_q + WAIT_CNT_W'(1);
      end
    end
  end

  assign bus.i_gnt        = i_gnt;
  assign bus.d_gnt        = d_gnt;
  assign bus.i_rdata      = bus.mem_rdata;
  assign bus.d_rdata      = bus.mem_rdata;
  assign bus.mem_read_en  = rd_en;
  assign bus.mem_write_en = wr_en;
  assign bus.mem_addr     = addr;
  assign bus.mem_wdata    = wdata;
  assign bus.mem_byte_en  = byte_en;
  assign bus.i_wait_cnt   = i_wait_q;
  assign bus.d_wait_cnt   = d_wait_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT_CNT_W, default 16, width of each per-requester wait-cycle counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  I-cache requests the backing memory (read-only refill).
REQ-005 i_last  input  1  current I-cache beat is the last of its transaction.
REQ-006 i_addr  input  32  I-cache byte address for the current beat.
REQ-007 i_gnt  output  1  I-cache owns the memory port this cycle.
REQ-008 i_rdata  output  32  mem_rdata forwarded to the I-cache.
REQ-009 d_req, d_we, d_last  input  1 each  D-cache request, write (1) or read (0), last beat.
REQ-010 d_addr, d_wdata  input  32 each  D-cache byte address and write data.
REQ-011 d_byte_en  input  4  D-cache write byte enables.
REQ-012 d_gnt  output  1  D-cache owns the memory port this cycle.
REQ-013 d_rdata  output  32  mem_rdata forwarded to the D-cache.
REQ-014 mem_read_en, mem_write_en  output  1 each  backing-memory command strobes.
REQ-015 mem_addr, mem_wdata  output  32 each; mem_byte_en  output  4; mem_rdata  input  32.
REQ-016 i_wait_cnt, d_wait_cnt  output  WAIT_CNT_W  cycles each requester spent requesting without grant.

Function
REQ-017 FSM states: IDLE, GNT_I, GNT_D; i_gnt = (state==GNT_I), d_gnt = (state==GNT_D), both registered-state decodes, never both 1.
REQ-018 IDLE: i_req only -> GNT_I; d_req only -> GNT_D; neither -> IDLE.
REQ-019 IDLE with i_req and d_req both 1: round-robin; grant the requester that did not win the previous arbitration; first arbitration after reset favours D.
REQ-020 Grant latency: request seen in IDLE at edge N -> gnt asserted in cycle N+1; no combinational req-to-gnt path.
REQ-021 Grant locks: owner keeps grant every cycle until a cycle with owner req=1 and last=1 (transaction end).
REQ-022 On transaction end: if other requester's req=1, switch directly to its grant state (no IDLE bubble); else go IDLE.
REQ-023 Owner drops req while granted without last: grant held, memory strobes 0 that cycle (stall tolerated).
REQ-024 GNT_I with i_req=1: mem_read_en=1, mem_write_en=0, mem_addr=i_addr, mem_wdata=0, mem_byte_en=4'b0000.
REQ-025 GNT_D with d_req=1: mem_read_en=~d_we, mem_write_en=d_we, mem_addr=d_addr, mem_wdata=d_wdata, mem_byte_en=d_we?d_byte_en:4'b0000.
REQ-026 Any other case (IDLE, or owner req=0): all mem_* outputs 0.
REQ-027 i_rdata = d_rdata = mem_rdata unconditionally; requesters qualify with own gnt.
REQ-028 Round-robin pointer updates only when a grant is issued (IDLE->GNT_x or handoff), records the winner.
REQ-029 x_wait_cnt increments by 1 each cycle x_req=1 and x_gnt=0; saturates at all-ones; never wraps; no other clear except reset.

Reset
REQ-030 Reset (asserted any time, including mid-transaction) forces IDLE, i_gnt=d_gnt=0, all mem_* strobes/enables 0, RR pointer to favour D, both wait counters 0, immediately without waiting for clk.
REQ-031 First grant possible in the cycle after the first rising edge with reset deasserted and a req present.

Verification
REQ-032 Single I read: i_req=1, i_addr=0x100, 4 beats, i_last on 4th -> i_gnt one cycle after req, mem_read_en=1 for 4 cycles with mem_addr=0x100, back to IDLE, i_wait_cnt=1.
REQ-033 Contention: i_req and d_req rise together in IDLE after reset -> d_gnt first; D read of 4 beats; then i_gnt in the very next cycle; i_wait_cnt=5.
REQ-034 D store: d_req=1, d_we=1, d_last=1, d_addr=0x40, d_wdata=0xCAFEF00D, d_byte_en=4'b0011 -> one cycle mem_write_en=1 with those values, mem_read_en=0, then IDLE.
REQ-035 Fairness: both requesters continuously requesting 1-beat transactions -> grants alternate D,I,D,I; never two consecutive grants to one side.
REQ-036 Reset mid-transaction: assert reset during beat 2 of a D read -> d_gnt and mem_read_en 0 immediately, counters 0; after release, pending i_req granted in one cycle.
REQ-037 Saturation: WAIT_CNT_W=4, hold i_req while D owns port for 20 cycles -> i_wait_cnt stops at 15.
